spi_mux_master: RTL
===================

# spi_mux_master

SPI initiator that drives the LED output multiplexer's SPI slave port from the controller side. It accepts 8-bit select bytes over a valid/ready handshake and sends each one as a single chip-select-framed transfer: SPI mode 0, LSB first. MISO is captured on every transfer and returned with a done strobe. It sits in the controller FPGA between the output-routing logic and the board-level SPI pins.

## Interface
- CLK_DIV, 4, SCK half-period in clk cycles; legal range 1..255
- CS_SETUP, 2, clk cycles from nCS fall to the first SCK rise; legal range 1..255
- CS_HOLD, 2, clk cycles from the last SCK fall to nCS rise; legal range 1..255
- IDLE_GAP, 2, clk cycles with nCS high before the next byte is accepted; legal range 0..255

Ports:
- clk  in  1  master clock, 50 MHz
- reset  in  1  synchronous, active-low
- tx_data  in  8  byte to send; bit 0 is transmitted first
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  block can accept a byte
- busy  out  1  transfer or gap in progress
- spi_nCS  out  1  chip select, active low
- spi_sck  out  1  SPI clock, idles low
- spi_mosi  out  1  master data out
- spi_miso  in  1  slave data in; may float, board pull applies
- rx_data  out  8  MISO byte of the last completed transfer
- done  out  1  one-cycle pulse when a transfer completes

## Operation
- All outputs are registered, except tx_ready and busy, which decode directly from the state.
- Reset values (while reset=0): state IDLE, spi_nCS=1, spi_sck=0, spi_mosi=0, rx_data=0, done=0, tx_ready=0, busy=0. All counters are 0.
- tx_ready = reset & (state==IDLE).
- busy = (state!=IDLE).
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- IDLE
  - On tx_valid & tx_ready: latch tx_data into the shift register, spi_nCS←0, spi_mosi←tx_data[0], bit_cnt←0, div_cnt←0, go to SETUP.
- SETUP
  - Lasts CS_SETUP cycles.
  - On exit: spi_sck←1, go to SCK_HI.
- SCK_HI
  - Lasts CLK_DIV cycles.
  - On exit: spi_sck←0 and rx_shift[bit_cnt]←spi_miso, sampled on the same edge.
  - If bit_cnt==7, go to HOLD.
  - Otherwise bit_cnt←bit_cnt+1, spi_mosi←shift[bit_cnt+1], go to SCK_LO.
- SCK_LO
  - Lasts CLK_DIV cycles.
  - On exit: spi_sck←1, go to SCK_HI.
- HOLD
  - Lasts CS_HOLD cycles. spi_mosi holds bit 7.
  - On exit: spi_nCS←1, spi_mosi←0, rx_data←rx_shift, done←1, go to GAP. If IDLE_GAP==0, go straight to IDLE instead.
- GAP
  - Lasts IDLE_GAP cycles, then go to IDLE.
- spi_mosi changes only on SCK falling edges, or while SCK is low. It is stable across every SCK rise.
- tx_valid and tx_data are ignored whenever the state is not IDLE. No queuing; a byte is accepted only when tx_ready=1.
- If tx_valid is held continuously, transfers run back to back, separated by IDLE_GAP+1 cycles with nCS high (GAP cycles plus the IDLE accept cycle).
- div_cnt is 8 bits. It resets to 0 on every state change and compares against (param−1).
- Reset asserted mid-transfer: at the next clk edge all outputs return to their reset values. The transfer is aborted with no done pulse and rx_data cleared. No partial SCK pulse extends past that edge.

## Timing
- Let E0 be the clk edge where tx_valid & tx_ready is sampled high.
  - spi_nCS falls at E0 and spi_mosi = d[0] at E0.
  - tx_ready drops after E0.
- Bit k (k=0..7):
  - SCK rises at E0+CS_SETUP+2k·CLK_DIV.
  - SCK falls at E0+CS_SETUP+(2k+1)·CLK_DIV.
  - MISO bit k is sampled at that falling edge.
- nCS rises and done pulses at T1 = E0+CS_SETUP+15·CLK_DIV+CS_HOLD.
- tx_ready reasserts at T1+IDLE_GAP.
- With default parameters: T1 = E0+64, tx_ready reasserts at E0+66, byte period 67 cycles, SCK = 6.25 MHz.
- Exactly 8 SCK rising edges occur per nCS-low window.

## Test plan
- Default parameters, send 0xA5. Required:
  - MOSI at the 8 SCK rises reads 1,0,1,0,0,1,0,1.
  - nCS low for exactly 64 cycles; done at E0+64.
  - tx_ready high again at E0+66.
- Hold tx_valid high with 0x01 then 0x80. Required:
  - Two nCS windows, each with 8 SCK pulses.
  - nCS high for exactly 3 cycles between them.
  - The second byte is not accepted before E0+66.
- Loopback MISO=MOSI with byte 0x3C. Required: rx_data=0x3C at the done pulse.
- Pulse tx_valid while busy. Required: no second transfer; tx_data changes during the transfer do not alter the bits already shifting.
- Assert reset after the 3rd SCK rise. Required:
  - Next edge: nCS=1, SCK=0, MOSI=0, no done, rx_data=0.
  - After reset is released, tx_ready is high on the first cycle.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, IDLE_GAP=0, send 0xFF. Required:
  - SCK toggles every cycle; nCS low for 17 cycles.
  - tx_ready reasserts in the cycle right after the done pulse edge.

Source files
------------

// File: rtl/spi_mux_master.sv
// SPI mode-0, LSB-first initiator that sends one select byte per chip-select frame
// to the LED output multiplexer and returns the byte captured on MISO.
module spi_mux_master #(
  parameter int CLK_DIV  = 4,  // SCK half-period in clk cycles, 1..255
  parameter int CS_SETUP = 2,  // nCS fall to first SCK rise, 1..255
  parameter int CS_HOLD  = 2,  // last SCK fall to nCS rise, 1..255
  parameter int IDLE_GAP = 2   // nCS-high cycles before the next accept, 0..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       spi_nCS,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic [7:0] rx_data,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GAP
  } state_t;

  // Terminal counts for div_cnt; each phase ends when div_cnt reaches param-1.
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST   = 8'(IDLE_GAP - 1);
  localparam bit         SKIP_GAP   = (IDLE_GAP == 0);

  state_t     state, state_n;
  logic [7:0] div_cnt, div_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       ncs_n, sck_n, mosi_n, done_n;
  logic [7:0] rx_data_n;

  assign tx_ready = reset & (state == IDLE);
  assign busy     = (state != IDLE);

  // NOTE: every variable gets its hold/default value before the case statement,
  // so no path through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt + 8'd1;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    ncs_n      = spi_nCS;
    sck_n      = spi_sck;
    mosi_n     = spi_mosi;
    rx_data_n  = rx_data;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        div_cnt_n = 8'd0;
        if (tx_valid && tx_ready) begin
          tx_shift_n = tx_data;
          ncs_n      = 1'b0;
          mosi_n     = tx_data[0];
          bit_cnt_n  = 3'd0;
          state_n    = SETUP;
        end
      end

      SETUP: begin
        if (div_cnt == SETUP_LAST) begin
          div_cnt_n = 8'd0;
          sck_n     = 1'b1;
          state_n   = SCK_HI;
        end
      end

      SCK_HI: begin
        if (div_cnt == DIV_LAST) begin
          // MISO is captured on the same edge that drops SCK.
          div_cnt_n            = 8'd0;
          sck_n                = 1'b0;
          rx_shift_n[bit_cnt]  = spi_miso;
          if (bit_cnt == 3'd7) begin
            state_n = HOLD;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            mosi_n    = tx_shift[bit_cnt_n];
            state_n   = SCK_LO;
          end
        end
      end

      SCK_LO: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_n = 8'd0;
          sck_n     = 1'b1;
          state_n   = SCK_HI;
        end
      end

      HOLD: begin
        if (div_cnt == HOLD_LAST) begin
          div_cnt_n = 8'd0;
          ncs_n     = 1'b1;
          mosi_n    = 1'b0;
          rx_data_n = rx_shift;
          done_n    = 1'b1;
          state_n   = SKIP_GAP ? IDLE : GAP;
        end
      end

      GAP: begin
        if (div_cnt == GAP_LAST) begin
          div_cnt_n = 8'd0;
          state_n   = IDLE;
        end
      end

      default: begin
        div_cnt_n = 8'd0;
        state_n   = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      spi_nCS  <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
      rx_data  <= 8'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      spi_nCS  <= ncs_n;
      spi_sck  <= sck_n;
      spi_mosi <= mosi_n;
      rx_data  <= rx_data_n;
      done     <= done_n;
    end
  end

endmodule
